cp0_reg: RTL and testbench



---
 rtl/cp0_reg.sv | 146 ++++++++++++++
 tb/tb_cp0_reg.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cp0_reg.sv
// cp0_reg: Coprocessor-0 register file.
// Holds Count, Compare, Status, Cause, EPC, PrId and Config. Writes arrive from
// the write-back stage; reads are combinational for mtc0/mfc0 handling in execute.
// Optional feature macro: CP0_TIMER_EN (free-running Count and Compare-match
// timer interrupt). When undefined, Count changes only on writes and
// timer_int_o is tied low.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active-low
//   we_i         write enable
//   waddr_i      CP0 register number to write
//   data_i       write data
//   raddr_i      CP0 register number to read
//   int_i        external hardware interrupt lines (level)
//   data_o       read data, combinational from raddr_i
//   count_o .. prid_o  live register values
//   timer_int_o  timer interrupt (level, sticky until Compare write)
module cp0_reg #(
    parameter logic [31:0] PRID_VALUE   = 32'h004c0102,
    parameter logic [31:0] CONFIG_VALUE = 32'h00008000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned IW = 6;

    localparam logic [AW-1:0] REG_COUNT   = AW'(9);
    localparam logic [AW-1:0] REG_COMPARE = AW'(11);
    localparam logic [AW-1:0] REG_STATUS  = AW'(12);
    localparam logic [AW-1:0] REG_CAUSE   = AW'(13);
    localparam logic [AW-1:0] REG_EPC     = AW'(14);
    localparam logic [AW-1:0] REG_PRID    = AW'(15);
    localparam logic [AW-1:0] REG_CONFIG  = AW'(16);

    localparam logic [DW-1:0] STATUS_RST  = 32'h1000_0000;

    // Cause is kept as its only live fields; all other bits read as zero.
    logic [IW-1:0] cause_ip_hw;
    logic [1:0]    cause_ip_sw;
    logic          cause_wp;
    logic          cause_iv;

    assign cause_o  = {8'h00, cause_iv, cause_wp, 6'h00, cause_ip_hw, cause_ip_sw, 8'h00};
    assign config_o = CONFIG_VALUE;
    assign prid_o   = PRID_VALUE;

`ifdef CP0_TIMER_EN
    // Match uses pre-edge count/compare; a Compare write in the same cycle clears.
    logic timer_match;
    assign timer_match = (compare_o != '0) && (count_o == compare_o);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_int_o <= 1'b0;
        end else if (we_i && waddr_i == REG_COMPARE) begin
            timer_int_o <= 1'b0;
        end else if (timer_match) begin
            timer_int_o <= 1'b1;
        end
    end
`else
    assign timer_int_o = 1'b0;
`endif

    // Count: write replaces that cycle's increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_o <= '0;
        end else if (we_i && waddr_i == REG_COUNT) begin
            count_o <= data_i;
        end else begin
`ifdef CP0_TIMER_EN
            count_o <= count_o + DW'(1);
`else
            count_o <= count_o;
`endif
        end
    end

    // Plain software-written registers and the writable Cause fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            compare_o   <= '0;
            status_o    <= STATUS_RST;
            epc_o       <= '0;
            cause_ip_sw <= '0;
            cause_wp    <= 1'b0;
            cause_iv    <= 1'b0;
        end else if (we_i) begin
            case (waddr_i)
                REG_COMPARE: compare_o <= data_i;
                REG_STATUS:  status_o  <= data_i;
                REG_EPC:     epc_o     <= data_i;
                REG_CAUSE: begin
                    cause_ip_sw <= data_i[9:8];
                    cause_wp    <= data_i[22];
                    cause_iv    <= data_i[23];
                end
                default: ;
            endcase
        end
    end

    // Hardware interrupt lines are sampled every cycle; software cannot override.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cause_ip_hw <= '0;
        end else begin
            cause_ip_hw <= int_i;
        end
    end

    // Read port: no write bypass, forwarding is handled in execute.
    always_comb begin
        data_o = '0;
        case (raddr_i)
            REG_COUNT:   data_o = count_o;
            REG_COMPARE: data_o = compare_o;
            REG_STATUS:  data_o = status_o;
            REG_CAUSE:   data_o = cause_o;
            REG_EPC:     data_o = epc_o;
            REG_PRID:    data_o = prid_o;
            REG_CONFIG:  data_o = config_o;
            default:     data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_reg.sv
// tb_cp0_reg: randomized and directed checks of cp0_reg against a
// behavioural model of the CP0 register rules.
module tb_cp0_reg;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] data_i;
    logic [4:0]  raddr_i;
    logic [5:0]  int_i;
    logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
    logic        timer_int_o;

    cp0_reg dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .data_i(data_i),
        .raddr_i(raddr_i), .int_i(int_i), .data_o(data_o), .count_o(count_o),
        .compare_o(compare_o), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
        .config_o(config_o), .prid_o(prid_o), .timer_int_o(timer_int_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef CP0_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Behavioural model: CP0 state as plain numbers.
    logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
    logic        m_timer;
    localparam logic [31:0] CAUSE_SW_MASK = 32'h00C0_0300;

    task automatic model_reset();
        m_count = 0; m_compare = 0; m_status = 32'h1000_0000;
        m_cause = 0; m_epc = 0; m_timer = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd9:  return m_count;
            5'd11: return m_compare;
            5'd12: return m_status;
            5'd13: return m_cause;
            5'd14: return m_epc;
            5'd15: return 32'h004c0102;
            5'd16: return 32'h0000_8000;
            default: return 32'h0;
        endcase
    endfunction

    // One clock edge of the architectural rules, from pre-edge values.
    always @(posedge clk) begin
        if (rst) begin
            logic        hit;
            logic [31:0] nxt;
            hit = TIMER && (m_compare != 0) && (m_count == m_compare);
            nxt = TIMER ? m_count + 32'd1 : m_count;
            if (hit) m_timer = 1'b1;
            if (we_i) begin
                case (waddr_i)
                    5'd9:  nxt = data_i;
                    5'd11: begin m_compare = data_i; m_timer = 1'b0; end
                    5'd12: m_status = data_i;
                    5'd13: m_cause = (m_cause & ~CAUSE_SW_MASK) | (data_i & CAUSE_SW_MASK);
                    5'd14: m_epc = data_i;
                    default: ;
                endcase
            end
            m_count = nxt;
            m_cause[15:10] = int_i;
        end
    end

    task automatic check_all();
        check("count",   count_o,   m_count);
        check("compare", compare_o, m_compare);
        check("status",  status_o,  m_status);
        check("cause",   cause_o,   m_cause);
        check("epc",     epc_o,     m_epc);
        check("config",  config_o,  32'h0000_8000);
        check("prid",    prid_o,    32'h004c0102);
        check("timer",   {31'b0, timer_int_o}, {31'b0, m_timer});
    endtask

    // Starts and ends at a negedge; checks read port before, state after the edge.
    task automatic tick(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [5:0] irq);
        we_i = w; waddr_i = a; data_i = d; int_i = irq;
        raddr_i = 5'($urandom_range(0, 31));
        #1;
        check("read", data_o, model_read(raddr_i));
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 5'd0, 32'h0, int_i);
    endtask

    initial begin
        logic [4:0] addrs [8];
        addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};
        rst = 1'b0; we_i = 0; waddr_i = 0; data_i = 0; raddr_i = 0; int_i = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_count", count_o, 32'h0);
        check("rst_status", status_o, 32'h1000_0000);
        check("rst_cause", cause_o, 32'h0);
        check("rst_timer", {31'b0, timer_int_o}, 32'h0);
        rst = 1'b1;

        // Five idle edges after release.
        idle(5);
        check("count_after5", count_o, TIMER ? 32'd5 : 32'd0);
        check("prid_const", prid_o, 32'h004c0102);

        // Compare match and sticky timer.
        tick(1'b1, 5'd11, 32'd20, 6'd0);
        tick(1'b1, 5'd9, 32'd15, 6'd0);
        idle(6);
        check("timer_set", {31'b0, timer_int_o}, {31'b0, TIMER});
        idle(3);
        check("timer_sticky", {31'b0, timer_int_o}, {31'b0, TIMER});
        tick(1'b1, 5'd11, 32'd100, 6'd0);
        check("timer_clear", {31'b0, timer_int_o}, 32'h0);

        // Compare write coinciding with a match: clear wins.
        tick(1'b1, 5'd11, 32'd30, 6'd0);
        tick(1'b1, 5'd9, 32'd30, 6'd0);
        tick(1'b1, 5'd11, 32'd30, 6'd0);
        check("clear_wins", {31'b0, timer_int_o}, 32'h0);
        // Count written equal to compare: match on the following edge.
        tick(1'b1, 5'd9, 32'd30, 6'd0);
        idle(1);
        check("count_eq_cmp", {31'b0, timer_int_o}, {31'b0, TIMER});

        // Count wrap.
        tick(1'b1, 5'd9, 32'hFFFF_FFFE, 6'd0);
        idle(1);
        check("wrap0", count_o, TIMER ? 32'hFFFF_FFFF : 32'hFFFF_FFFE);
        idle(1);
        check("wrap1", count_o, TIMER ? 32'h0 : 32'hFFFF_FFFE);
        idle(1);
        check("wrap2", count_o, TIMER ? 32'h1 : 32'hFFFF_FFFE);

        // Cause write mask with simultaneous interrupt lines.
        tick(1'b1, 5'd13, 32'hFFFF_FFFF, 6'b101010);
        check("cause_mask", cause_o, 32'h00C0_AB00);

        // Read-only and unlisted registers.
        tick(1'b1, 5'd15, 32'h0, 6'b101010);
        tick(1'b1, 5'd16, 32'h0, 6'b101010);
        raddr_i = 5'd15; #1 check("rd_prid", data_o, 32'h004c0102);
        raddr_i = 5'd16; #1 check("rd_config", data_o, 32'h0000_8000);
        raddr_i = 5'd3;  #1 check("rd_unlisted", data_o, 32'h0);
        @(negedge clk);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [4:0]  a;
            logic [31:0] d;
            a = addrs[$urandom_range(0, 7)];
            d = $urandom;
            if (a == 5'd11 && $urandom_range(0, 1) == 1) d = m_count + 32'($urandom_range(0, 6));
            if (a == 5'd9 && $urandom_range(0, 1) == 1) d = m_compare - 32'($urandom_range(0, 4));
            tick(1'($urandom_range(0, 1)), a, d, 6'($urandom));
        end

        // Asynchronous reset mid-count with timer asserted.
        tick(1'b1, 5'd11, 32'd5, 6'd0);
        tick(1'b1, 5'd9, 32'd5, 6'd0);
        tick(1'b1, 5'd9, 32'd1000, 6'd0);
        check("pre_rst_count", count_o, 32'd1000);
        check("pre_rst_timer", {31'b0, timer_int_o}, {31'b0, TIMER});
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("async_count", count_o, 32'h0);
        check("async_timer", {31'b0, timer_int_o}, 32'h0);
        check("async_status", status_o, 32'h1000_0000);
        @(negedge clk);
        @(negedge clk);
        check("hold_count", count_o, 32'h0);
        rst = 1'b1;
        idle(1);
        check("first_edge", count_o, TIMER ? 32'd1 : 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
